// File: rtl/dmem_pkg.sv
// ============================================================================
//  dmem_pkg
//  Shared constants for the dmem responder: MMIO offsets, STATUS bit layout
//  and the default MMIO window base.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_FFF0;

    localparam logic [31:0] TX_OFS     = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd1;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;

endpackage : dmem_pkg

`default_nettype wire

// File: rtl/dmem_out_fifo.sv
// ============================================================================
//  dmem_out_fifo
//  Synchronous FIFO feeding the MMIO output channel. A push into a full FIFO
//  without a same-cycle pop is dropped and raises a sticky overflow flag.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_out_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clr_ovf,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (push && !do_push) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_valid = !empty;
    assign head_data  = empty ? '0 : mem[rd_ptr];
    assign count      = cnt;
    assign overflow   = ovf;

endmodule : dmem_out_fifo

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
//  dmem_responder
//  Word-addressed data RAM with one-cycle read-first loads, plus an optional
//  MMIO TX FIFO and STATUS register enabled by the DMEM_MMIO_EN macro.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_BITS  = 12,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = DEFAULT_MMIO_BASE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0]          mem [2**ADDR_BITS];
    logic [ADDR_BITS-1:0] idx;
    logic                 ram_we;
    logic [31:0]          rd_word;

    assign idx = address_dmem[ADDR_BITS-1:0];

`ifdef DMEM_MMIO_EN
    logic             is_tx;
    logic             is_status;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_ovf;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      status_word;

    assign is_tx     = (address_dmem == MMIO_BASE + TX_OFS);
    assign is_status = (address_dmem == MMIO_BASE + STATUS_OFS);
    assign ram_we    = wren && !is_tx && !is_status;

    // Reset wins over a same-cycle TX store inside the FIFO.
    dmem_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_out_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (wren && is_tx),
        .push_data  (data),
        .pop        (out_ready),
        .clr_ovf    (wren && is_status),
        .head_valid (out_valid),
        .head_data  (out_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .overflow   (fifo_ovf)
    );

    always_comb begin
        status_word                       = '0;
        status_word[ST_CNT_LSB +: CNT_W]  = fifo_count;
        status_word[ST_OVF]               = fifo_ovf;
        status_word[ST_FULL]              = fifo_full;
        status_word[ST_EMPTY]             = fifo_empty;
    end

    always_comb begin
        rd_word = mem[idx];
        if (is_tx) begin
            rd_word = '0;
        end else if (is_status) begin
            rd_word = status_word;
        end
    end
`else
    logic unused_cfg;

    assign ram_we     = wren;
    assign rd_word    = mem[idx];
    assign out_valid  = 1'b0;
    assign out_data   = '0;
    assign unused_cfg = ^{out_ready, address_dmem[31:ADDR_BITS], MMIO_BASE,
                          CNT_W[0]};
`endif

    // RAM has no reset so a store coincident with reset still lands.
    always_ff @(posedge clock) begin
        if (ram_we) mem[idx] <= data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_dmem <= '0;
        end else begin
            q_dmem <= rd_word;
        end
    end

endmodule : dmem_responder

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
//  tb_dmem_responder
//  Directed self-checking bench for dmem_responder; MMIO checks are compiled
//  in when DMEM_MMIO_EN is defined, alias checks otherwise.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'hFFFF_FFF0;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    int vectors;
    int miscompares;

    dmem_responder #(
        .ADDR_BITS  (12),
        .FIFO_DEPTH (8),
        .MMIO_BASE  (BASE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        address_dmem = a;
        data         = d;
        wren         = 1'b1;
        step();
        wren         = 1'b0;
    endtask

    task automatic load(input logic [31:0] a);
        address_dmem = a;
        wren         = 1'b0;
        step();
    endtask

`ifdef DMEM_MMIO_EN
    logic [31:0] exp_q [$];
`endif

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        address_dmem = '0;
        data         = '0;
        wren         = 1'b0;
        out_ready    = 1'b0;
        step();
        step();
        check("reset_q", q_dmem, 32'h0);
        check("reset_valid", {31'h0, out_valid}, 32'h0);
        check("reset_data", out_data, 32'h0);
        reset = 1'b0;

        store(32'd5, 32'hDEAD_BEEF);
        load(32'd5);
        check("load5", q_dmem, 32'hDEAD_BEEF);
        load(32'd5 + 32'd4096);
        check("alias5", q_dmem, 32'hDEAD_BEEF);

        store(32'd7, 32'h11);
        address_dmem = 32'd7;
        data         = 32'h22;
        wren         = 1'b1;
        step();
        wren         = 1'b0;
        check("rdw_old", q_dmem, 32'h11);
        step();
        check("rdw_new", q_dmem, 32'h22);

`ifdef DMEM_MMIO_EN
        store(BASE, 32'hA);
        check("tx_lat_valid", {31'h0, out_valid}, 32'h1);
        check("tx_lat_data", out_data, 32'hA);
        store(BASE, 32'hB);
        store(BASE, 32'hC);
        load(BASE + 32'd1);
        check("status_3", q_dmem, 32'h30);
        load(BASE);
        check("tx_load", q_dmem, 32'h0);
        address_dmem = 32'd0;
        out_ready    = 1'b1;
        check("drain_a", out_data, 32'hA);
        step();
        check("drain_b", out_data, 32'hB);
        step();
        check("drain_c", out_data, 32'hC);
        step();
        check("drain_done", {31'h0, out_valid}, 32'h0);
        out_ready = 1'b0;
        load(BASE + 32'd1);
        check("status_empty", q_dmem, 32'h1);

        for (int i = 1; i <= 9; i++) store(BASE, 32'h100 + i);
        load(BASE + 32'd1);
        check("status_ovf", q_dmem, 32'h86);
        check("ovf_head", out_data, 32'h101);
        store(BASE + 32'd1, 32'hFFFF_FFFF);
        load(BASE + 32'd1);
        check("status_clr", q_dmem, 32'h82);

        out_ready = 1'b1;
        store(BASE, 32'h99);
        out_ready = 1'b0;
        load(BASE + 32'd1);
        check("full_pushpop", q_dmem, 32'h82);
        for (int i = 2; i <= 8; i++) exp_q.push_back(32'h100 + i);
        exp_q.push_back(32'h99);
        out_ready    = 1'b1;
        address_dmem = 32'd0;
        while (exp_q.size() > 0) begin
            check("full_drain", out_data, exp_q.pop_front());
            step();
        end
        check("full_drain_end", {31'h0, out_valid}, 32'h0);

        store(BASE, 32'h77);
        check("empty_pushpop_v", {31'h0, out_valid}, 32'h1);
        check("empty_pushpop_d", out_data, 32'h77);
        step();
        check("empty_pushpop_pop", {31'h0, out_valid}, 32'h0);
        out_ready = 1'b0;

        for (int i = 0; i < 4; i++) store(BASE, 32'h200 + i);
        store(32'd9, 32'h1234);
`else
        store(32'd9, 32'h1234);
`endif

        reset        = 1'b1;
        address_dmem = 32'd10;
        data         = 32'hABCD;
        wren         = 1'b1;
        step();
        reset = 1'b0;
        wren  = 1'b0;
        check("rst_q", q_dmem, 32'h0);
        check("rst_valid", {31'h0, out_valid}, 32'h0);
`ifdef DMEM_MMIO_EN
        load(BASE + 32'd1);
        check("rst_status", q_dmem, 32'h1);
`endif
        load(32'd9);
        check("rst_ram9", q_dmem, 32'h1234);
        load(32'd10);
        check("rst_ram10", q_dmem, 32'hABCD);

`ifndef DMEM_MMIO_EN
        out_ready = 1'b1;
        store(BASE, 32'h55);
        check("nommio_valid", {31'h0, out_valid}, 32'h0);
        load(BASE);
        check("nommio_load", q_dmem, 32'h55);
        load(32'h0000_0FF0);
        check("nommio_alias", q_dmem, 32'h55);
        check("nommio_data", out_data, 32'h0);
        out_ready = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dmem_responder

`default_nettype wire
